// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter feeding one mesh output port from NUM_REQ FIFO heads.
// The winning head is popped the same cycle into a small FIFO buffer.
// The buffer is presented downstream with a pending/pop handshake.
module mesh_port_arbiter #(
  parameter int NUM_REQ   = 16,
  parameter int PKG_SZ    = 40,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          pndng_in,
  input  logic [NUM_REQ*PKG_SZ-1:0]   data_in,
  output logic [NUM_REQ-1:0]          pop_out,
  output logic                        pndng_out,
  output logic [PKG_SZ-1:0]           data_out,
  input  logic                        popin,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [IW:0]   NREQ  = (IW+1)'(NUM_REQ);
  localparam logic [AW:0]   DEPTH = (AW+1)'(OUT_DEPTH);
  localparam logic [IW-1:0] LAST  = IW'(NUM_REQ-1);

  logic [NUM_REQ-1:0][PKG_SZ-1:0]   req_data;
  logic [OUT_DEPTH-1:0][PKG_SZ-1:0] mem;
  logic [AW-1:0]                    wr_ptr, rd_ptr;
  logic [AW:0]                      count;
  logic [IW-1:0]                    rr;
  logic [IW-1:0]                    winner;
  logic [IW:0]                      idx;
  logic                             found, arb_en, grant, drain;

  assign req_data = data_in;

  // Arbitration uses the registered occupancy only, so a slot freed by a
  // downstream pop this cycle is not reused until the next cycle.
  assign arb_en = reset && (count < DEPTH);
  assign grant  = arb_en && found;
  assign drain  = reset && popin && (count != '0);

  // First pending requester at or after rr, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr} + (IW+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && pndng_in[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  // One-hot pop to the winner; all zero when blocked, idle or in reset.
  always_comb begin
    pop_out = '0;
    if (grant) pop_out[winner] = 1'b1;
  end

  // Buffer storage and write side; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
    end else if (grant) begin
      mem[wr_ptr] <= req_data[winner];
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  // Round-robin pointer and last grant index advance only on a grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr       <= '0;
      grant_id <= '0;
    end else if (grant) begin
      rr       <= (winner == LAST) ? '0 : winner + IW'(1);
      grant_id <= winner;
    end
  end

  // Read side and forwarded-packet counter; pops on an empty buffer are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else if (drain) begin
      rd_ptr    <= rd_ptr + AW'(1);
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({grant, drain})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign pndng_out = (count != '0);
  assign data_out  = mem[rd_ptr];

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Randomized and directed bench for mesh_port_arbiter against a queue-based model.
module tb_mesh_port_arbiter;

  localparam int N   = 16;
  localparam int PKG = 40;
  localparam int D   = 4;
  localparam int CW  = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         pndng_in;
  logic [N*PKG-1:0]     data_in;
  logic [N-1:0]         pop_out;
  logic                 pndng_out;
  logic [PKG-1:0]       data_out;
  logic                 popin;
  logic [$clog2(N)-1:0] grant_id;
  logic [CW-1:0]        pkt_count;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // Behavioural model: a plain queue of buffered packets plus pointers.
  logic [PKG-1:0] mq[$];
  int             m_rr  = 0;
  int             m_gid = 0;
  logic [CW-1:0]  m_pkt = '0;

  mesh_port_arbiter #(.NUM_REQ(N), .PKG_SZ(PKG), .OUT_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pndng_in(pndng_in), .data_in(data_in),
    .pop_out(pop_out), .pndng_out(pndng_out), .data_out(data_out),
    .popin(popin), .grant_id(grant_id), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    if (!reset || mq.size() >= D) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (pndng_in[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic step();
    int w;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_rr = 0; m_gid = 0; m_pkt = '0;
    end else begin
      w = m_winner();
      if (popin && mq.size() != 0) begin
        void'(mq.pop_front());
        m_pkt = m_pkt + 1'b1;
      end
      if (w >= 0) begin
        mq.push_back(data_in[w*PKG +: PKG]);
        m_rr  = (w + 1) % N;
        m_gid = w;
      end
    end
    #1;
  endtask

  task automatic set_d(input int i, input logic [PKG-1:0] v);
    data_in[i*PKG +: PKG] = v;
  endtask

  task automatic rand_data();
    logic [63:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom, $urandom};
      set_d(i, t[PKG-1:0]);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] ep;
    if (started) begin
      w  = m_winner();
      ep = '0;
      if (w >= 0) ep[w] = 1'b1;
      chk("pop_out", pop_out, ep);
      chk("pndng_out", pndng_out, (mq.size() != 0));
      if (mq.size() != 0) chk("data_out", data_out, mq[0]);
      chk("grant_id", grant_id, m_gid);
      chk("pkt_count", pkt_count, m_pkt);
    end
  end

  initial begin
    // Reset held with everything asserted.
    reset = 1'b0; popin = 1'b1; pndng_in = '1; rand_data();
    step();
    started = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_pop", pop_out, 0);
      chk("rst_pndng", pndng_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_cnt", pkt_count, 0);
      step();
    end

    // Round-robin fairness: all requesting, data = index, downstream always pops.
    reset = 1'b1; pndng_in = '1; popin = 1'b1;
    for (int i = 0; i < N; i++) set_d(i, PKG'(i));
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk("rr_pop", pop_out, 64'(1) << (k % 16));
      if (k >= 1) begin
        chk("rr_data", data_out, (k - 1) % 16);
        chk("rr_cnt", pkt_count, k - 1);
      end
      step();
    end

    // Skip and wrap: park rr at 14, then only 3 and 9 request.
    pndng_in = 16'h2000;
    @(negedge clk); chk("skip_set", pop_out, 64'h2000); step();
    pndng_in = 16'h0208;
    @(negedge clk); chk("skip_a", pop_out, 64'h0008); step();
    @(negedge clk); chk("skip_b", pop_out, 64'h0200); chk("skip_gid_a", grant_id, 3); step();
    @(negedge clk); chk("skip_c", pop_out, 64'h0008); chk("skip_gid_b", grant_id, 9); step();
    pndng_in = '0;
    @(negedge clk); chk("skip_gid_c", grant_id, 3); step();
    repeat (2) step();

    // Backpressure to full, then release and simultaneous push/pop at 3.
    popin = 1'b0; pndng_in = 16'h0020;
    for (int j = 0; j < 9; j++) begin
      popin = (j == 5 || j == 6);
      set_d(5, PKG'(32'h100 + j));
      @(negedge clk);
      if (j == 0) chk("bp_empty", pndng_out, 0);
      if (j == 1) chk("bp_first", data_out, 40'h100);
      chk("bp_pop", pop_out, (j < 4 || j == 6 || j == 7) ? 64'h20 : 64'h0);
      if (j == 4) chk("bp_full_pndng", pndng_out, 1);
      if (j == 6) chk("bp_head6", data_out, 40'h101);
      if (j == 7) chk("bp_head7", data_out, 40'h102);
      step();
    end
    pndng_in = '0; popin = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      case (j)
        0: chk("drain0", data_out, 40'h102);
        1: chk("drain1", data_out, 40'h103);
        2: chk("drain2", data_out, 40'h106);
        3: chk("drain3", data_out, 40'h107);
        default: chk("drain_empty", pndng_out, 0);
      endcase
      step();
    end

    // Reset mid-burst with three packets buffered.
    popin = 1'b0; pndng_in = 16'h0080;
    for (int k = 0; k < 3; k++) begin
      set_d(7, PKG'(32'h200 + k));
      step();
    end
    reset = 1'b0;
    @(negedge clk); chk("mid_rst_pop", pop_out, 0); step();
    reset = 1'b1; pndng_in = 16'h0004; set_d(2, 40'h3AB);
    @(negedge clk);
    chk("mid_pndng", pndng_out, 0);
    chk("mid_cnt", pkt_count, 0);
    chk("mid_pop", pop_out, 64'h4);
    step();
    pndng_in = '0;
    @(negedge clk);
    chk("mid_data", data_out, 40'h3AB);
    chk("mid_pndng1", pndng_out, 1);
    step();

    // Randomized traffic with varying downstream pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      pp = (i / 500) % 3;
      reset = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 3))
        0: pndng_in = '0;
        1: pndng_in = N'($urandom);
        2: pndng_in = N'($urandom) & N'($urandom) & N'($urandom);
        default: pndng_in = N'(1) << $urandom_range(0, N - 1);
      endcase
      popin = (pp == 0) ? ($urandom_range(0, 3) != 0) :
              (pp == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      rand_data();
      step();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_port_arbiter.md
# mesh_port_arbiter

Round-robin arbiter that shares one mesh output port among all terminal FIFOs of the bus mesh. Each requester exposes a FIFO head via a pending/data pair. The arbiter pops the winning head into a small output buffer and presents it downstream through the same pending/pop handshake. It sits between the per-terminal input FIFOs and a single mesh router ingress or a monitor/checker sink.

## Interface
- NUM_REQ, 16, number of requesters (ROWS*2+COLUMNS*2 for a 4x4 mesh); must be ≥2
- PKG_SZ, 40, packet width in bits
- OUT_DEPTH, 4, output buffer depth in entries; must be a power of 2 and ≥2
- CNT_W, 16, width of the forwarded-packet counter

- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset
- pndng_in  input  NUM_REQ  bit i high: requester i FIFO head is valid
- data_in  input  NUM_REQ*PKG_SZ  requester i head in bits [i*PKG_SZ +: PKG_SZ]
- pop_out  output  NUM_REQ  one-hot pop to the granted requester; head consumed at this clk edge
- pndng_out  output  1  output buffer non-empty
- data_out  output  PKG_SZ  output buffer head; valid while pndng_out=1
- popin  input  1  downstream pop; consumes data_out at this clk edge
- grant_id  output  $clog2(NUM_REQ)  index of the last granted requester
- pkt_count  output  CNT_W  packets forwarded downstream; wraps modulo 2^CNT_W

## Operation
- State: output buffer storage (OUT_DEPTH×PKG_SZ), write pointer, read pointer, occupancy `count` (0..OUT_DEPTH), round-robin pointer `rr` (0..NUM_REQ-1), grant_id, pkt_count.
- Arbitration is enabled in a cycle when reset=1 and registered count < OUT_DEPTH. A buffer slot freed by popin in the same cycle does not enable arbitration.
- When enabled, the winner is the first index i with pndng_in[i]=1, searching rr, rr+1, …, NUM_REQ-1, 0, …, rr-1.
- pop_out[winner]=1 combinationally. All other bits are 0. pop_out is all zero if arbitration is disabled or no pndng_in bit is high.
- On a grant at the clk edge:
  - data_in[winner] is written at the write pointer;
  - the write pointer increments with wrap;
  - rr ← (winner+1) mod NUM_REQ;
  - grant_id ← winner.
- rr and grant_id hold when there is no grant.
- A requester may drop pndng_in without being granted. There is no lock and no penalty.
- pndng_out = (count≠0). data_out = storage[read pointer].
- popin with pndng_out=1: the read pointer increments with wrap and pkt_count increments. popin with pndng_out=0 is ignored and no state changes.
- Simultaneous grant and popin: count is unchanged and both pointers advance.
- Buffer full (count=OUT_DEPTH): no pop_out is issued, and requesters are not consumed or reordered.
- Reset (reset=0 at a clk edge), including mid-operation:
  - count, pointers, rr, grant_id and pkt_count ← 0;
  - all storage entries ← 0;
  - buffered packets are discarded.
- While reset=0, pop_out is forced to 0.
- Reset values: pndng_out=0, data_out=0, pop_out=0, grant_id=0, pkt_count=0.

## Timing
- Grant latency is 0 cycles: pop_out is asserted in the same cycle as pndng_in when arbitration is enabled.
- Forward latency is 1 cycle: a packet popped at edge t appears on data_out/pndng_out after edge t if the buffer was empty.
- Sustained throughput is 1 packet/cycle when downstream pops every cycle and count < OUT_DEPTH.
- pndng_out, data_out, grant_id and pkt_count are registered. pop_out is combinational from pndng_in and registered state only.
- data_in is sampled only at the edge where the corresponding pop_out bit is high.

## Test plan
- Reset check: hold reset=0 for 3 cycles with all pndng_in=1 and popin=1 -> pop_out=0, pndng_out=0, data_out=0, pkt_count=0 throughout. First release cycle -> pop_out=0x0001.
- Round-robin fairness: pndng_in=0xFFFF constant, data_in[i]=i, popin=1 every cycle -> pop_out walks 0x0001, 0x0002, …, 0x8000, 0x0001. data_out sequence is 0,1,…,15,0 starting one cycle after the first grant. pkt_count=16 after 16 pops.
- Skip and wrap: rr=14, pndng_in bits {3,9} only -> grant 3, then 9, then 3. grant_id follows 3, 9, 3.
- Backpressure and full: popin=0, pndng_in[5]=1 constant -> exactly 4 pops, then pndng_out=1 with pop_out=0. popin=1 for one cycle -> no pop that cycle and one pop the next cycle. data_out order is preserved FIFO.
- Simultaneous push/pop at full-minus-one: count=3, grant and popin in the same cycle -> count stays 3 and the data order is preserved. popin while empty -> pkt_count unchanged.
- Reset mid-burst: buffer holds 3 packets, assert reset=0 for 1 cycle -> pndng_out=0 and pkt_count=0. The next packet forwarded is the first one granted after release.
